// File: rtl/calc_pkg.sv
// Shared types, widths and defaults for the calculator request sequencer.
package calc_pkg;

  localparam int OPND_W = 4;
  localparam int OP_W   = 3;
  localparam int RES_W  = 8;
  localparam int BCD_W  = 16;

  localparam int               TIMEOUT_CYCLES_DEF = 64;
  localparam logic [BCD_W-1:0] ERR_PATTERN_DEF    = 16'hEEEE;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_CONV  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_ERR   = 3'd5
  } calc_state_e;

endpackage

// File: rtl/go_edge.sv
// Registers the debounced go level and flags its rising edge for one cycle.
module go_edge (
  input  logic clk,
  input  logic rst,
  input  logic go,
  output logic go_rise
);

  logic go_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) go_q <= 1'b0;
    else     go_q <= go;
  end

  assign go_rise = go & ~go_q;

endmodule

// File: rtl/calc_sequencer.sv
// Runs one capture -> execute -> BCD convert -> display cycle per go edge,
// with a bounded wait on the converter and a sticky error display on timeout.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int               TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [BCD_W-1:0] ERR_PATTERN    = ERR_PATTERN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [OPND_W-1:0] a_in,
  input  logic [OPND_W-1:0] b_in,
  input  logic [OP_W-1:0]   op_in,
  output logic [OPND_W-1:0] op_a,
  output logic [OPND_W-1:0] op_b,
  output logic [OP_W-1:0]   op_sel,
  input  logic [RES_W-1:0]  alu_result,
  output logic              conv_en,
  output logic [BCD_W-1:0]  conv_bin,
  input  logic [BCD_W-1:0]  conv_bcd,
  input  logic              conv_ready,
  output logic [BCD_W-1:0]  disp_bcd,
  output logic              disp_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  calc_state_e      state;
  logic             go_rise;
  logic [RES_W-1:0] result_reg;
  logic [TMR_W-1:0] timer;

  go_edge u_go_edge (
    .clk     (clk),
    .rst     (rst),
    .go      (go),
    .go_rise (go_rise)
  );

  assign conv_bin  = {{(BCD_W-RES_W){1'b0}}, result_reg};
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_a       <= '0;
      op_b       <= '0;
      op_sel     <= '0;
      result_reg <= '0;
      timer      <= '0;
      conv_en    <= 1'b0;
      disp_bcd   <= '0;
      disp_en    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      conv_en <= 1'b0;
      done    <= 1'b0;
      case (state)
        ST_IDLE, ST_ERR: begin
          if (go_rise) begin
            op_a   <= a_in;
            op_b   <= b_in;
            op_sel <= op_in;
            err    <= 1'b0;
            busy   <= 1'b1;
            state  <= ST_LATCH;
          end
        end
        ST_LATCH: state <= ST_EXEC;
        ST_EXEC: begin
          result_reg <= alu_result;
          conv_en    <= 1'b1;
          state      <= ST_CONV;
        end
        ST_CONV: begin
          timer <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          timer <= timer + 1'b1;
          // timer==0 is the first WAIT cycle; a ready seen there may be left over
          // from the previous conversion. Ready takes priority over timeout.
          if (timer != '0 && conv_ready) begin
            disp_bcd <= conv_bcd;
            disp_en  <= 1'b1;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else if (timer == TMR_LAST) begin
            disp_bcd <= ERR_PATTERN;
            disp_en  <= 1'b1;
            err      <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_ERR;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with ALU and bin2bcd behavioural models
// and a queue-based scoreboard checked by an independent monitor.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [3:0]  a_in, b_in;
  logic [2:0]  op_in;
  logic [3:0]  op_a, op_b;
  logic [2:0]  op_sel;
  logic [7:0]  alu_result;
  logic        conv_en;
  logic [15:0] conv_bin;
  logic [15:0] conv_bcd = 16'h0000;
  logic        conv_ready = 1'b0;
  logic [15:0] disp_bcd;
  logic        disp_en, busy, done, err;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  calc_sequencer dut (
    .clk(clk), .rst(rst), .go(go), .a_in(a_in), .b_in(b_in), .op_in(op_in),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .alu_result(alu_result),
    .conv_en(conv_en), .conv_bin(conv_bin), .conv_bcd(conv_bcd),
    .conv_ready(conv_ready), .disp_bcd(disp_bcd), .disp_en(disp_en),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // Operation unit model: 0 add, 1 subtract, 2 multiply.
  always_comb begin
    case (op_sel)
      3'd0:    alu_result = 8'(op_a) + 8'(op_b);
      3'd1:    alu_result = 8'(op_a) - 8'(op_b);
      3'd2:    alu_result = 8'(op_a) * 8'(op_b);
      default: alu_result = 8'h00;
    endcase
  end

  function automatic logic [15:0] to_bcd(input logic [7:0] v);
    int n;
    n = int'(v);
    return {4'd0, 4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // bin2bcd model. mode 0: drop ready at start, raise after delay and hold.
  // mode 1: leave a stale ready up for one more cycle before dropping it.
  // mode 2: never answer.
  int         mode = 0;
  int         delay = 18;
  int         cnt = 0;
  logic       pending = 1'b0;
  logic [7:0] lat_bin = 8'h00;

  always @(posedge clk) begin
    if (conv_en) begin
      lat_bin <= conv_bin[7:0];
      if (mode != 1) conv_ready <= 1'b0;
      pending <= (mode != 2);
      cnt     <= delay;
    end else if (pending) begin
      if (cnt == 1) begin
        conv_ready <= 1'b1;
        conv_bcd   <= to_bcd(lat_bin);
        pending    <= 1'b0;
      end else begin
        conv_ready <= 1'b0;
        cnt        <= cnt - 1;
      end
    end
  end

  // Scoreboard entry: {err expected, disp_bcd expected}
  logic [16:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int          conv_cnt = 0, done_cnt = 0;
  int          conv_cyc = 0, done_cyc = 0, err_cyc = 0;
  logic [15:0] conv_bin_seen = 16'h0;
  logic        done_prev = 1'b0, err_prev = 1'b0;

  task automatic sb_pop(input string name);
    logic [16:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected completion got %0h expected none", name, {err, disp_bcd});
    end else begin
      e = exp_q.pop_front();
      chk(name, 32'({err, disp_bcd}), 32'(e));
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      done_prev = 1'b0;
      err_prev  = 1'b0;
    end else begin
      if (conv_en) begin
        conv_cnt++;
        conv_cyc      = cyc;
        conv_bin_seen = conv_bin;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (done_prev) chk("done_width", 32'(done_prev & done), 32'd0);
        sb_pop("sb_done");
      end
      if (err && !err_prev) begin
        err_cyc = cyc;
        sb_pop("sb_err");
      end
      done_prev = done;
      err_prev  = err;
    end
  end

  int go_cyc = 0;

  task automatic start_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                          input logic [16:0] exp, input bit push);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    op_in = op;
    go    = 1'b1;
    go_cyc = cyc + 1;
    if (push) exp_q.push_back(exp);
  endtask

  task automatic release_go();
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  int c0, d0;

  initial begin
    rst = 1'b1; go = 1'b0; a_in = '0; b_in = '0; op_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        32'({op_a, op_b, op_sel, conv_en, disp_en, busy, done, err}), 32'd0);
    chk("reset_disp", 32'(disp_bcd), 32'd0);
    chk("reset_conv_bin", 32'(conv_bin), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic add 5+3
    mode = 0; delay = 18;
    c0 = conv_cnt; d0 = done_cnt;
    start_op(4'd5, 4'd3, 3'd0, {1'b0, 16'h0008}, 1'b1);
    release_go();
    chk("busy_in_flight", 32'(busy), 32'd1);
    drain(100);
    chk("basic_conv_lat", 32'(conv_cyc - go_cyc), 32'd2);
    chk("basic_conv_bin", 32'(conv_bin_seen), 32'h0008);
    chk("basic_done_lat", 32'(done_cyc - go_cyc), 32'd22);
    chk("basic_conv_cnt", 32'(conv_cnt - c0), 32'd1);
    @(negedge clk);
    chk("basic_busy_after", 32'(busy), 32'd0);
    chk("basic_disp_en", 32'(disp_en), 32'd1);
    chk("basic_op_regs", 32'({op_a, op_b, op_sel}), 32'({4'd5, 4'd3, 3'd0}));

    // Stale ready: 15*15 = 225
    mode = 1; delay = 6;
    start_op(4'd15, 4'd15, 3'd2, {1'b0, 16'h0225}, 1'b1);
    release_go();
    drain(100);
    chk("stale_conv_bin", 32'(conv_bin_seen), 32'h00E1);
    chk("stale_done_lat", 32'(done_cyc - go_cyc), 32'd10);

    // Timeout, then recovery with 2+2
    mode = 2;
    start_op(4'd1, 4'd1, 3'd0, {1'b1, 16'hEEEE}, 1'b1);
    release_go();
    drain(200);
    chk("timeout_lat", 32'(err_cyc - go_cyc), 32'd67);
    @(negedge clk);
    chk("err_state", 32'({err, busy, disp_en}), 32'b101);
    mode = 0; delay = 18;
    start_op(4'd2, 4'd2, 3'd0, {1'b0, 16'h0004}, 1'b1);
    @(negedge clk);
    chk("err_cleared", 32'({err, busy}), 32'b01);
    go = 1'b0;
    drain(100);

    // Requests and operand changes during WAIT are ignored: 7+6 = 13
    c0 = conv_cnt; d0 = done_cnt;
    start_op(4'd7, 4'd6, 3'd0, {1'b0, 16'h0013}, 1'b1);
    release_go();
    repeat (8) @(negedge clk);
    go = 1'b1; a_in = 4'd15;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    drain(100);
    repeat (10) @(negedge clk);
    chk("ignore_conv_cnt", 32'(conv_cnt - c0), 32'd1);
    chk("ignore_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("ignore_op_a", 32'(op_a), 32'd7);

    // go held high for 100 cycles: 9+9 = 18
    c0 = conv_cnt; d0 = done_cnt;
    start_op(4'd9, 4'd9, 3'd0, {1'b0, 16'h0018}, 1'b1);
    repeat (100) @(negedge clk);
    go = 1'b0;
    drain(20);
    repeat (5) @(negedge clk);
    chk("held_conv_cnt", 32'(conv_cnt - c0), 32'd1);
    chk("held_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Asynchronous reset in WAIT, then a fresh 3+4
    start_op(4'd4, 4'd4, 3'd0, 17'h0, 1'b0);
    release_go();
    for (int i = 0; i < 20; i++) begin
      if (dbg_state == 3'd4) break;
      @(negedge clk);
    end
    chk("reach_wait", 32'(dbg_state), 32'd4);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs",
        32'({op_a, op_b, op_sel, conv_en, disp_en, busy, done, err, dbg_state}), 32'd0);
    chk("async_rst_disp", 32'(disp_bcd), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    d0 = done_cnt;
    start_op(4'd3, 4'd4, 3'd0, {1'b0, 16'h0007}, 1'b1);
    release_go();
    drain(100);
    chk("post_rst_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("post_rst_op_regs", 32'({op_a, op_b}), 32'({4'd3, 4'd4}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
